// File: rtl/cursor_pkg.sv
// Shared types for the grid cursor controller: FSM states and decoded button commands.
package cursor_pkg;

   typedef enum logic [1:0] {IDLE, DEBOUNCE, ACT, HOLD} state_t;

   typedef enum logic [2:0] {NONE, UP, DOWN, LEFT, RIGHT, SEL} cmd_t;

   function automatic logic is_move(input cmd_t c);
      return (c == UP) || (c == DOWN) || (c == LEFT) || (c == RIGHT);
   endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the five raw buttons plus a single-button command encoder.
module btn_sync
   import cursor_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [4:0] btn,      // {sel, right, left, down, up}
   output cmd_t       cmd
);

   logic [4:0] meta;
   logic [4:0] sync;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= btn;
         sync <= meta;
      end
   end

   // Chords and releases both decode to NONE so they can never act.
   always_comb begin
      cmd = NONE;
      case (sync)
         5'b00001: cmd = UP;
         5'b00010: cmd = DOWN;
         5'b00100: cmd = LEFT;
         5'b01000: cmd = RIGHT;
         5'b10000: cmd = SEL;
         default:  cmd = NONE;
      endcase
   end

endmodule

// File: rtl/cursor_ctrl.sv
// Debounced, auto-repeating cursor over a COLS x ROWS board with overlay position
// and a valid/ready select handshake toward game logic.
module cursor_ctrl
   import cursor_pkg::*;
#(
   parameter int COLS         = 3,
   parameter int ROWS         = 3,
   parameter int CELL         = 32,
   parameter int ORIGIN_X     = 272,
   parameter int ORIGIN_Y     = 192,
   parameter int DB_TICKS     = 2,
   parameter int REPEAT_TICKS = 10,
   parameter bit WRAP         = 1'b1,
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          frame_tick,
   input  logic          btn_up,
   input  logic          btn_down,
   input  logic          btn_left,
   input  logic          btn_right,
   input  logic          btn_sel,
   input  logic          lock,
   input  logic          sel_ready,
   output logic [CW-1:0] cell_col,
   output logic [RW-1:0] cell_row,
   output logic [9:0]    top_left_x,
   output logic [9:0]    top_left_y,
   output logic          sel_valid,
   output logic [CW-1:0] sel_col,
   output logic [RW-1:0] sel_row,
   output state_t        fsm_state
);

   // Select handshake: sel_valid rises with sel_col/sel_row stable and stays high
   // until a cycle where sel_valid && sel_ready; the clear lands on the next edge.

   localparam int CNT_MAX = (DB_TICKS > REPEAT_TICKS) ? DB_TICKS : REPEAT_TICKS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

   cmd_t             cmd;
   cmd_t             latched;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             apply;
   logic             repeat_due;
   logic [CW-1:0]    col_next;
   logic [RW-1:0]    row_next;

   btn_sync u_btn_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     ({btn_sel, btn_right, btn_left, btn_down, btn_up}),
      .cmd     (cmd)
   );

   assign fsm_state = state;

   assign repeat_due = (state == HOLD) && (cmd == latched) && is_move(latched)
                       && frame_tick && (cnt == CNT_W'(REPEAT_TICKS - 1));
   assign apply = (state == ACT) || repeat_due;

   always_comb begin
      col_next = cell_col;
      row_next = cell_row;
      case (latched)
         UP:    row_next = (cell_row == '0)    ? (WRAP ? ROW_MAX : cell_row) : cell_row - RW'(1);
         DOWN:  row_next = (cell_row == ROW_MAX) ? (WRAP ? '0 : cell_row)    : cell_row + RW'(1);
         LEFT:  col_next = (cell_col == '0)    ? (WRAP ? COL_MAX : cell_col) : cell_col - CW'(1);
         RIGHT: col_next = (cell_col == COL_MAX) ? (WRAP ? '0 : cell_col)    : cell_col + CW'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         latched    <= NONE;
         cnt        <= '0;
         cell_col   <= '0;
         cell_row   <= '0;
         top_left_x <= 10'(ORIGIN_X);
         top_left_y <= 10'(ORIGIN_Y);
         sel_valid  <= 1'b0;
         sel_col    <= '0;
         sel_row    <= '0;
      end else begin
         top_left_x <= 10'(ORIGIN_X + int'(cell_col) * CELL);
         top_left_y <= 10'(ORIGIN_Y + int'(cell_row) * CELL);

         if (apply && !lock && is_move(latched)) begin
            cell_col <= col_next;
            cell_row <= row_next;
         end

         // An acknowledge in the same cycle as a new select wins; the new select is lost.
         if (sel_valid && sel_ready) begin
            sel_valid <= 1'b0;
         end else if (apply && !lock && (latched == SEL) && !sel_valid) begin
            sel_valid <= 1'b1;
            sel_col   <= cell_col;
            sel_row   <= cell_row;
         end

         case (state)
            IDLE: begin
               if (cmd != NONE) begin
                  state   <= DEBOUNCE;
                  latched <= cmd;
                  cnt     <= '0;
               end
            end
            DEBOUNCE: begin
               if (cmd != latched) begin
                  state <= IDLE;
               end else if (frame_tick) begin
                  if (cnt == CNT_W'(DB_TICKS - 1)) begin
                     state <= ACT;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            ACT: begin
               state <= HOLD;
               cnt   <= '0;
            end
            HOLD: begin
               if (cmd != latched) begin
                  state <= IDLE;
               end else if (is_move(latched) && frame_tick) begin
                  cnt <= repeat_due ? '0 : cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/cursor_ctrl.md
# cursor_ctrl

Grid cursor controller that sequences the 32x32 cursor overlay: turns raw push-button presses into debounced, auto-repeating moves of a cell index on a COLS x ROWS board. It drives the overlay's `top_left_x`/`top_left_y` and issues a select handshake to game logic. It sits between the board button inputs, the VGA sync frame tick, and the pixel-generation / game-state blocks.

## Interface
- `COLS`, 3: board columns (1..16)
- `ROWS`, 3: board rows (1..16)
- `CELL`, 32: cell pitch in pixels
- `ORIGIN_X`, 272: pixel x of cell (0,0) top-left
- `ORIGIN_Y`, 192: pixel y of cell (0,0) top-left
- `DB_TICKS`, 2: frame ticks a press must be stable before it acts
- `REPEAT_TICKS`, 10: frame ticks between auto-repeat moves while held
- `WRAP`, 1: 1 = wrap at edges, 0 = saturate

Ports:
- `clk` in 1: system clock
- `reset_n` in 1: synchronous, active-low reset
- `frame_tick` in 1: one-cycle pulse per video frame
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_sel` in 1 each: raw asynchronous buttons, active-high
- `lock` in 1: 1 = moves and selects suppressed
- `sel_ready` in 1: game logic accepts the select
- `cell_col` out CW = $clog2(COLS): current column
- `cell_row` out RW = $clog2(ROWS): current row
- `top_left_x`, `top_left_y` out 10: cursor overlay position
- `sel_valid` out 1: select pending
- `sel_col` out CW, `sel_row` out RW: cell captured at select

## Operation
- Buttons pass through a 2-flop synchronizer.
- `cmd` = the single asserted button. Zero or ≥2 asserted gives `cmd` = NONE.
- FSM states:
  - IDLE: `cmd` != NONE → DEBOUNCE. Latch `cmd`, clear `cnt`.
  - DEBOUNCE: `cmd` != latched → IDLE. On `frame_tick`, `cnt`++. When `cnt` == DB_TICKS → ACT.
  - ACT: one cycle, applies the latched command, then → HOLD with `cnt` cleared.
  - HOLD: `cmd` != latched → IDLE. For a latched move only: on `frame_tick`, `cnt`++; when `cnt` == REPEAT_TICKS, apply the move again and clear `cnt`. A latched select never repeats.
- Move rules:
  - up: row−1; down: row+1; left: col−1; right: col+1.
  - At an edge, WRAP=1 goes 0 ↔ max; WRAP=0 holds the value.
  - `lock`=1 at the apply cycle cancels the apply. FSM transitions are unaffected.
- Select rules:
  - Applied with `lock`=0 and `sel_valid`=0: set `sel_valid`, capture `sel_col`/`sel_row` from the current cell.
  - Applied while `sel_valid`=1: dropped, no overwrite.
  - `sel_valid` && `sel_ready` clears `sel_valid` next cycle.
- Position: `top_left_x` = ORIGIN_X + `cell_col`*CELL, `top_left_y` = ORIGIN_Y + `cell_row`*CELL. Computed from registered indices and output registered. Widths are truncated to 10 bits; the integrator guarantees the grid fits 640x480.

## Timing
- Reset (`reset_n`=0 at a clk edge):
  - state IDLE, `cnt` 0.
  - `cell_col`=`cell_row`=0.
  - `top_left_x`=ORIGIN_X, `top_left_y`=ORIGIN_Y.
  - `sel_valid`=0, `sel_col`=`sel_row`=0.
- Reset mid-operation aborts any debounce, hold or pending select.
- Input to `cmd`: 2 cycles (synchronizer).
- Apply to `cell_*`: 1 cycle. `cell_*` to `top_left_*`: 1 further cycle.
- First move occurs on the DB_TICKS-th `frame_tick` after `cmd` becomes stable, plus 1 cycle (ACT).
- Repeat period is exactly REPEAT_TICKS frame ticks.
- `sel_valid` rises the cycle after ACT. It stays high until the cycle after a `sel_ready` sample.
- Simultaneous events:
  - `frame_tick` in the same cycle as a `cmd` change: the change wins (→ IDLE).
  - `sel_ready` with a new select apply in the same cycle: the clear wins; the new select is dropped.

## Structure
- Package `cursor_pkg`: state enum (IDLE, DEBOUNCE, ACT, HOLD) and command enum (NONE, UP, DOWN, LEFT, RIGHT, SEL).
- One sub-module, `btn_sync`: a 5-bit 2-flop synchronizer plus one-hot/NONE command encoder.
- FSM, counters, index update and position multiply stay in `cursor_ctrl`.

## Test plan
Parameters use the defaults listed above.
- Reset: hold `reset_n`=0 for 3 cycles → `top_left_x`=272, `top_left_y`=192, `sel_valid`=0.
- Right press, released after 4 ticks → `cell_col`=1 after the 2nd tick, `top_left_x`=304. No repeat.
- Right held for 25 ticks → `cell_col` sequence 1, 2, 0 (wrap) at ticks 2, 12, 22. With WRAP=0 the sequence is 1, 2, 2.
- Right glitch lasting 1 tick, or up+left pressed together → no move.
- Select at cell (1,1) with `sel_ready`=0 for 5 cycles → `sel_valid`=1, `sel_col`=`sel_row`=1. A second select during this period is dropped. `sel_ready`=1 → `sel_valid`=0 next cycle.
- `lock`=1 during a down press → `cell_row` stays 0. Then reset asserted mid-HOLD → state IDLE and all outputs at reset values.
